vector_exec_unit: RTL



---
 rtl/vp_pkg.sv | 28 ++
 rtl/vp_lane_mul.sv | 20 ++
 rtl/vector_exec_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vp_pkg.sv
// Shared types and derived-width helpers for the vector execution core.
// Opcode and state encodings live here so the core and its submodules agree on them.
package vp_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_ADD,
    S_MUL,
    S_DONE
  } state_t;

  function automatic int lanes_f(input int vlen, input int ew);
    return vlen / ew;
  endfunction

  function automatic int instr_w_f(input int nreg, input int addr_w);
    return 2 + $clog2(nreg) + addr_w;
  endfunction

endpackage

// File: rtl/vp_lane_mul.sv
// One lane group of signed EW x EW multipliers, purely combinational.
// Each product is 2*EW bits wide: the low half goes to R3 and the high half to R4.
module vp_lane_mul #(
  parameter int EW        = 32,
  parameter int MUL_LANES = 4
) (
  input  logic [MUL_LANES*EW-1:0]   a_i,
  input  logic [MUL_LANES*EW-1:0]   b_i,
  output logic [MUL_LANES*2*EW-1:0] p_o
);

  for (genvar i = 0; i < MUL_LANES; i++) begin : g_lane
    logic signed [2*EW-1:0] ax;
    logic signed [2*EW-1:0] bx;
    assign ax = {{EW{a_i[i*EW+EW-1]}}, a_i[i*EW +: EW]};
    assign bx = {{EW{b_i[i*EW+EW-1]}}, b_i[i*EW +: EW]};
    assign p_o[i*2*EW +: 2*EW] = ax * bx;
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Vector execution core: FSM, register file, memory port and lane-serial multiplier sequencing.
// state  | meaning
// IDLE   | ready for an instruction
// MEM    | LOAD/STORE request outstanding, waiting for mem_ack
// ADD    | element-wise add of captured R1/R2 into R3
// MUL    | one lane group per cycle into shadow regs; R3/R4 commit on exit
// DONE   | one-cycle retire pulse
module vector_exec_unit
  import vp_pkg::*;
#(
  parameter int VLEN      = 512,
  parameter int EW        = 32,
  parameter int NREG      = 4,
  parameter int ADDR_W    = 9,
  parameter int MUL_LANES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  logic [instr_w_f(NREG, ADDR_W)-1:0] instr,
  output logic                              done,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [VLEN-1:0]                   mem_wdata,
  input  logic [VLEN-1:0]                   mem_rdata,
  input  logic                              mem_ack,
  output logic [NREG*VLEN-1:0]              regs
);

  localparam int LANES  = lanes_f(VLEN, EW);
  localparam int IW     = instr_w_f(NREG, ADDR_W);
  localparam int RW     = $clog2(NREG);
  localparam int GROUPS = LANES / MUL_LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GW     = MUL_LANES * EW;

  state_t            state_q, state_d;
  op_t               op_in, op_q;
  logic [RW-1:0]     rd_in, rd_q;
  logic [ADDR_W-1:0] addr_in, addr_q;
  logic [VLEN-1:0]   wdata_q, src1_q, src2_q;
  logic [VLEN-1:0]   lo_q, hi_q, lo_d, hi_d, sum;
  logic [VLEN-1:0]   rf_q [NREG];
  logic [CW-1:0]     cnt_q, grp;
  logic [GW-1:0]     mul_a, mul_b;
  logic [2*GW-1:0]   prod;
  int                gbase;
  logic              accept;

  assign op_in   = op_t'(instr[IW-1 -: 2]);
  assign rd_in   = instr[ADDR_W +: RW];
  assign addr_in = instr[ADDR_W-1:0];
  assign accept  = instr_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          case (op_in)
            OP_LOAD, OP_STORE: state_d = S_MEM;
            OP_ADD:            state_d = S_ADD;
            default:           state_d = S_MUL;
          endcase
        end
      end
      S_MEM:   if (mem_ack) state_d = S_DONE;
      S_ADD:   state_d = S_DONE;
      S_MUL:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Down-counter runs GROUPS-1..0; the group index counts up from 0.
  assign grp   = CW'(GROUPS - 1) - cnt_q;
  assign gbase = int'(grp) * GW;
  assign mul_a = src1_q[gbase +: GW];
  assign mul_b = src2_q[gbase +: GW];

  vp_lane_mul #(.EW(EW), .MUL_LANES(MUL_LANES)) u_lane_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    for (int i = 0; i < MUL_LANES; i++) begin
      lo_d[gbase + i*EW +: EW] = prod[2*i*EW +: EW];
      hi_d[gbase + i*EW +: EW] = prod[2*i*EW + EW +: EW];
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum[i*EW +: EW] = src1_q[i*EW +: EW] + src2_q[i*EW +: EW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_LOAD;
      rd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (accept) begin
        op_q  <= op_in;
        rd_q  <= rd_in;
        cnt_q <= CW'(GROUPS - 1);
        if (op_in == OP_LOAD || op_in == OP_STORE) addr_q <= addr_in;
        if (op_in == OP_STORE) wdata_q <= rf_q[rd_in];
        if (op_in == OP_ADD || op_in == OP_MUL) begin
          src1_q <= rf_q[0];
          src2_q <= rf_q[1];
        end
      end
      if (state_q == S_MEM && mem_ack && op_q == OP_LOAD) rf_q[rd_q] <= mem_rdata;
      if (state_q == S_ADD) rf_q[2] <= sum;
      if (state_q == S_MUL) begin
        lo_q  <= lo_d;
        hi_q  <= hi_d;
        cnt_q <= cnt_q - 1'b1;
        // The final group is folded in here so R3/R4 change together, never partially.
        if (cnt_q == '0) begin
          rf_q[2] <= lo_d;
          rf_q[3] <= hi_d;
        end
      end
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign mem_req     = (state_q == S_MEM);
  assign mem_we      = mem_req && (op_q == OP_STORE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

  for (genvar r = 0; r < NREG; r++) begin : g_regs
    assign regs[r*VLEN +: VLEN] = rf_q[r];
  end

endmodule
